// File: rtl/slc3_io_pkg.sv
// rtl/slc3_io_pkg.sv - shared types and constants for the SLC-3 key controller
package slc3_io_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PAUSED    = 2'd1,
    ACK       = 2'd2,
    WAIT_DROP = 2'd3
  } pause_state_t;

  localparam int   SW_WIDTH_DEF = 10;
  localparam logic KEY_PRESSED  = 1'b0;

endpackage

// File: rtl/slc3_key_controller_if.sv
// rtl/slc3_key_controller_if.sv - board keys/switches and CPU pause handshake bundle
interface slc3_key_controller_if
  import slc3_io_pkg::*;
#(
  parameter int SW_WIDTH = SW_WIDTH_DEF
);
  logic                Run_n;
  logic                Continue_n;
  logic [SW_WIDTH-1:0] SW;
  logic                pause_req;
  logic [SW_WIDTH-1:0] pause_data;
  logic                run_pulse;
  logic                continue_pulse;
  logic                soft_reset;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                paused;
  logic                continue_ack;
  logic [SW_WIDTH-1:0] LED;

  modport master (
    output Run_n, Continue_n, SW, pause_req, pause_data,
    input  run_pulse, continue_pulse, soft_reset, sw_sync, paused, continue_ack, LED
  );

  modport slave (
    input  Run_n, Continue_n, SW, pause_req, pause_data,
    output run_pulse, continue_pulse, soft_reset, sw_sync, paused, continue_ack, LED
  );
endinterface

// File: rtl/slc3_key_controller_key_debounce.sv
// rtl/slc3_key_controller_key_debounce.sv - per-key synchronizer, debounce counter and press event
module key_debounce
  import slc3_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   db_n;
  logic                   db_n_d;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced  = sync[SYNC_STAGES-1];
  assign pressed = (db_n == KEY_PRESSED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '1;
      db_n      <= ~KEY_PRESSED;
      db_n_d    <= ~KEY_PRESSED;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], key_n};
      db_n_d    <= db_n;
      press_evt <= (db_n == KEY_PRESSED) && (db_n_d != KEY_PRESSED);
      // Any sample that agrees with the debounced level restarts the stability count
      if (synced == db_n) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_n <= synced;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/slc3_key_controller.sv
// rtl/slc3_key_controller.sv - SLC-3 Run/Continue key responder with soft-reset gesture and pause handshake
module slc3_key_controller
  import slc3_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int SW_WIDTH        = SW_WIDTH_DEF
) (
  input logic                  Clk,
  input logic                  Reset_n,
  slc3_key_controller_if.slave io
);
  logic run_db, cont_db, run_evt, cont_evt;
  logic lockout, combo, run_p, cont_p;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_chain;
  pause_state_t        state;
  logic [SW_WIDTH-1:0] led;

  key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(Clk), .rst_n(Reset_n), .key_n(io.Run_n), .pressed(run_db), .press_evt(run_evt)
  );

  key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont (
    .clk(Clk), .rst_n(Reset_n), .key_n(io.Continue_n), .pressed(cont_db), .press_evt(cont_evt)
  );

  // Gesture fires on the first cycle both keys are held; press events trail it and hit the lockout
  assign combo  = run_db & cont_db & ~lockout;
  assign run_p  = run_evt & ~lockout & ~combo;
  assign cont_p = cont_evt & ~lockout & ~combo;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_chain <= '0;
      lockout  <= 1'b0;
    end else begin
      sw_chain <= {sw_chain[SYNC_STAGES-2:0], io.SW};
      if (combo) begin
        lockout <= 1'b1;
      end else if (!run_db && !cont_db) begin
        lockout <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      led   <= '0;
    end else if (combo) begin
      state <= IDLE;
      led   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.pause_req) begin
            led   <= io.pause_data;
            state <= PAUSED;
          end
        end
        PAUSED:    if (cont_p) state <= ACK;
        ACK:       state <= WAIT_DROP;
        WAIT_DROP: if (!io.pause_req) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign io.run_pulse      = run_p;
  assign io.continue_pulse = cont_p;
  assign io.soft_reset     = combo;
  assign io.sw_sync        = sw_chain[SYNC_STAGES-1];
  assign io.paused         = (state == PAUSED);
  assign io.continue_ack   = (state == ACK);
  assign io.LED            = led;
endmodule

// File: tb/tb_slc3_key_controller.sv
// tb/tb_slc3_key_controller.sv - self-checking bench for slc3_key_controller
module tb_slc3_key_controller;
  localparam int SYNC    = 2;
  localparam int DEB     = 2;
  localparam int W       = 10;
  localparam int T_SOFT  = SYNC + DEB;
  localparam int T_PULSE = SYNC + DEB + 1;

  logic         Clk     = 1'b0;
  logic         Reset_n = 1'b0;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           m_state = 0;
  logic [W-1:0] m_led   = '0;
  logic [W-1:0] prev_sw = '0;
  logic         p_cont  = 1'b0;
  logic         p_soft  = 1'b0;

  slc3_key_controller_if #(.SW_WIDTH(W)) io ();

  slc3_key_controller #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .SW_WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .io(io)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_run"},    32'(io.run_pulse),      32'd0);
    check({tag, "_cont"},   32'(io.continue_pulse), 32'd0);
    check({tag, "_soft"},   32'(io.soft_reset),     32'd0);
    check({tag, "_paused"}, 32'(io.paused),         32'd0);
    check({tag, "_ack"},    32'(io.continue_ack),   32'd0);
    check({tag, "_led"},    32'(io.LED),            32'd0);
    check({tag, "_sw"},     32'(io.sw_sync),        32'd0);
  endtask

  // act: 0 Run press, 1 Continue press, 2 both keys together, 3 no key
  task automatic run_window(input int act, input int len, input logic preq,
                            input logic [W-1:0] pdata, input logic [W-1:0] sw);
    logic er, ec, es;
    io.pause_req  = preq;
    io.pause_data = pdata;
    io.SW         = sw;
    for (int e = 1; e <= len + 9; e++) begin
      io.Run_n      = !((act == 0 || act == 2) && e <= len);
      io.Continue_n = !((act == 1 || act == 2) && e <= len);
      @(posedge Clk);
      if (p_soft) begin
        m_state = 0;
        m_led   = '0;
      end else begin
        case (m_state)
          0:       if (preq) begin m_state = 1; m_led = pdata; end
          1:       if (p_cont) m_state = 2;
          2:       m_state = 3;
          default: if (!preq) m_state = 0;
        endcase
      end
      er = (act == 0) && (len >= DEB) && (e == T_PULSE);
      ec = (act == 1) && (len >= DEB) && (e == T_PULSE);
      es = (act == 2) && (len >= DEB) && (e == T_SOFT);
      p_cont = ec;
      p_soft = es;
      @(negedge Clk);
      check($sformatf("run_pulse[a%0d l%0d e%0d]", act, len, e), 32'(io.run_pulse), 32'(er));
      check($sformatf("continue_pulse[a%0d l%0d e%0d]", act, len, e), 32'(io.continue_pulse), 32'(ec));
      check($sformatf("soft_reset[a%0d l%0d e%0d]", act, len, e), 32'(io.soft_reset), 32'(es));
      check($sformatf("paused[e%0d]", e), 32'(io.paused), 32'(m_state == 1));
      check($sformatf("continue_ack[e%0d]", e), 32'(io.continue_ack), 32'(m_state == 2));
      check($sformatf("LED[e%0d]", e), 32'(io.LED), 32'(m_led));
      check($sformatf("sw_sync[e%0d]", e), 32'(io.sw_sync), 32'((e >= SYNC) ? sw : prev_sw));
    end
    prev_sw = sw;
  endtask

  initial begin
    io.Run_n      = 1'b1;
    io.Continue_n = 1'b1;
    io.SW         = '0;
    io.pause_req  = 1'b0;
    io.pause_data = '0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset_n = 1'b1;

    run_window(0, 3, 1'b0, '0, '0);
    run_window(0, 1, 1'b0, '0, '0);
    run_window(2, 2, 1'b0, '0, '0);

    run_window(3, 0, 1'b1, 10'h003, '0);
    run_window(1, 3, 1'b1, 10'h003, '0);
    run_window(3, 0, 1'b1, 10'h003, '0);
    run_window(3, 0, 1'b0, 10'h003, '0);

    run_window(3, 0, 1'b0, '0, 10'h004);
    run_window(3, 0, 1'b0, '0, 10'h005);

    run_window(3, 0, 1'b1, 10'h007, 10'h005);
    Reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_state = 0;
    m_led   = '0;
    prev_sw = '0;
    p_cont  = 1'b0;
    p_soft  = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    run_window(3, 0, 1'b1, 10'h009, 10'h005);
    run_window(3, 0, 1'b0, 10'h009, 10'h005);

    for (int i = 0; i < 40; i++) begin
      run_window($urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                 10'($urandom), 10'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
